// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch (IF) and load/store (DM).
// Every access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE; simultaneous requests alternate.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_dm_q, owner_dm_d;
    logic          last_dm_q, last_dm_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          busy_q, busy_d;
    logic          grant_dm;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dm_d  = owner_dm_q;
        last_dm_d   = last_dm_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        grant_dm    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    // On a tie the requester that did not win last time gets the port.
                    grant_dm    = dm_req && (!if_req || !last_dm_q);
                    owner_dm_d  = grant_dm;
                    last_dm_d   = grant_dm;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dm && dm_we;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d    = CNT_LOAD;
                mem_we_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Stores capture too (value is don't-care), but only into their own register.
                    if (owner_dm_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            owner_dm_q  <= 1'b0;
            last_dm_q   <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dm_q  <= owner_dm_d;
            last_dm_q   <= last_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ML   = 2;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(ML), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- memory model (fixed latency, garbage when no read is due) ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C08_0004;
            32'h0000_0044: return 32'h1234_5678;
            32'h0000_0080: return 32'hCAFE_F00D;
            default:       return (a * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
        endcase
    endfunction

    logic [31:0] mem    [4096];
    bit          mem_wr [4096] = '{default: 1'b0};
    logic [31:0] rd_pipe [ML];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_wr[a[13:2]]) return mem[a[13:2]];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        for (int i = ML - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en && !mem_we) rd_pipe[0] <= mem_rd(mem_addr);
        else                   rd_pipe[0] <= $urandom;
        if (mem_en && mem_we) begin
            mem[mem_addr[13:2]]    <= mem_wdata;
            mem_wr[mem_addr[13:2]] <= 1'b1;
        end
    end
    assign mem_rdata = rd_pipe[ML-1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk1({name, "_if_ack"}, if_ack, 1'b0);
        chk1({name, "_dm_ack"}, dm_ack, 1'b0);
        chk1({name, "_mem_en"}, mem_en, 1'b0);
        chk1({name, "_mem_we"}, mem_we, 1'b0);
        chk1({name, "_busy"}, busy, 1'b0);
        chk({name, "_if_rdata"}, if_rdata, 32'h0);
        chk({name, "_dm_rdata"}, dm_rdata, 32'h0);
        chk({name, "_mem_addr"}, mem_addr, 32'h0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic inputs_idle();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        inputs_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Requests are already on the inputs in the current (IDLE) cycle T; walk T+1..T+ML+3.
    task automatic wait_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit chk_data,
                            input logic [31:0] exp_data);
        logic [31:0] other_before;
        other_before = is_dm ? if_rdata : dm_rdata;
        for (int k = 1; k <= ML + 3; k++) begin
            @(negedge clk);
            chk1("mem_en", mem_en, k == 1);
            if (k == 1) begin
                chk1("mem_we", mem_we, we);
                chk("mem_addr", mem_addr, addr);
                if (we) chk("mem_wdata", mem_wdata, wdata);
                // owner withdraws and scrambles its fields; the latched access must not change
                if (is_dm) begin
                    dm_req = 1'b0; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
                end else begin
                    if_req = 1'b0; if_addr = $urandom;
                end
            end
            chk1("if_ack", if_ack, !is_dm && (k == ML + 2));
            chk1("dm_ack", dm_ack, is_dm && (k == ML + 2));
            chk1("busy", busy, k <= ML + 2);
            if (k == ML + 2 && chk_data)
                chk(is_dm ? "dm_rdata" : "if_rdata", is_dm ? dm_rdata : if_rdata, exp_data);
            chk(is_dm ? "if_rdata_kept" : "dm_rdata_kept", is_dm ? if_rdata : dm_rdata, other_before);
        end
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    // ---------------- reference model state for the random phase ----------------
    int          m_issue, m_ack, m_idle;
    bit          m_owner_dm, m_last_dm, m_we;
    logic [31:0] m_addr, m_wdata, m_data;
    logic [31:0] exp_if, exp_dm;
    bit          if_known, dm_known;
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h0000_3000 + ($urandom_range(31) << 2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C08_0004};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_F00D};

        // reset held two cycles with random inputs
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
            @(negedge clk);
            chk_all_zero("rst");
        end
        reset = 1'b0;
        inputs_idle();
        @(negedge clk);
        chk_all_zero("rst_release");

        // single transactions from the vector table
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].is_dm) begin
                dm_req = 1'b1; dm_we = vecs[v].we; dm_addr = vecs[v].addr; dm_wdata = vecs[v].wdata;
            end else begin
                if_req = 1'b1; if_addr = vecs[v].addr;
            end
            wait_txn(vecs[v].is_dm, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                     !vecs[v].we, vecs[v].rdata);
        end

        // tie right after reset: IF first, then the pending DM
        pulse_reset();
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        wait_txn(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, init_word(32'h100));
        wait_txn(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, init_word(32'h200));
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h204;
        wait_txn(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, init_word(32'h104));
        wait_txn(1'b1, 1'b0, 32'h204, 32'h0, 1'b1, init_word(32'h204));
        if_req = 1'b1; if_addr = 32'h108;
        wait_txn(1'b0, 1'b0, 32'h108, 32'h0, 1'b1, init_word(32'h108));
        if_req = 1'b1; if_addr = 32'h10C;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h208;
        wait_txn(1'b1, 1'b0, 32'h208, 32'h0, 1'b1, init_word(32'h208));
        wait_txn(1'b0, 1'b0, 32'h10C, 32'h0, 1'b1, init_word(32'h10C));

        // reset while a fetch is in flight
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk1("inflight_mem_en", mem_en, 1'b1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("inflight_rst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("inflight_no_ack", if_ack, 1'b0);
            chk1("inflight_busy", busy, 1'b0);
            chk1("inflight_mem_en2", mem_en, 1'b0);
        end
        // last_grant went back to DM, so a tie goes to IF
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        wait_txn(1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 32'h1234_5678);
        wait_txn(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BAD_F00D);

        // fetch request held through its ack is served again back-to-back
        if_req = 1'b1; if_addr = 32'h0;
        for (int k = 1; k <= 2 * ML + 6; k++) begin
            @(negedge clk);
            chk1("hold_mem_en", mem_en, (k == 1) || (k == ML + 4));
            if (k == 1)      chk("hold_mem_addr0", mem_addr, 32'h0);
            if (k == ML + 4) chk("hold_mem_addr1", mem_addr, 32'h4);
            chk1("hold_if_ack", if_ack, (k == ML + 2) || (k == 2 * ML + 5));
            chk1("hold_dm_ack", dm_ack, 1'b0);
            chk1("hold_busy", busy, !((k == ML + 3) || (k == 2 * ML + 6)));
            if (k == ML + 2) begin
                chk("hold_if_rdata0", if_rdata, init_word(32'h0));
                if_addr = 32'h4;
            end
            if (k == 2 * ML + 5) chk("hold_if_rdata1", if_rdata, init_word(32'h4));
            if (k == ML + 4) if_req = 1'b0;
        end

        // random traffic against the transaction-level model
        m_issue = -1; m_ack = -1; m_idle = 0;
        m_owner_dm = 1'b0; m_last_dm = 1'b1; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_data = '0;
        exp_if = '0; exp_dm = '0; if_known = 1'b0; dm_known = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            bit rst, granted;
            @(negedge clk);
            if (c > 0) begin
                if (c == m_ack) begin
                    if (m_owner_dm) begin
                        if (m_we) dm_known = 1'b0;
                        else begin exp_dm = m_data; dm_known = 1'b1; end
                    end else begin
                        exp_if = m_data; if_known = 1'b1;
                    end
                end
                chk1("rnd_mem_en", mem_en, c == m_issue);
                if (c == m_issue) begin
                    chk1("rnd_mem_we", mem_we, m_we);
                    chk("rnd_mem_addr", mem_addr, m_addr);
                    if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
                end
                chk1("rnd_if_ack", if_ack, (c == m_ack) && !m_owner_dm);
                chk1("rnd_dm_ack", dm_ack, (c == m_ack) && m_owner_dm);
                chk1("rnd_busy", busy, (m_issue >= 0) && (c >= m_issue) && (c <= m_ack));
                if (if_known) chk("rnd_if_rdata", if_rdata, exp_if);
                if (dm_known) chk("rnd_dm_rdata", dm_rdata, exp_dm);
            end

            rst = (c == 0) || ($urandom_range(199) == 0);
            granted = (m_issue >= 0) && (c >= m_issue) && (c < m_ack);
            if (c == m_ack && !m_owner_dm) begin
                if ($urandom_range(1) == 1) if_addr = rand_addr();
                else if_req = 1'b0;
            end else if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = rand_addr(); end
            end else if (granted && !m_owner_dm && $urandom_range(1) == 1) begin
                if_addr = rand_addr();
            end
            if (c == m_ack && m_owner_dm) begin
                if ($urandom_range(1) == 1) begin
                    dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
                end else dm_req = 1'b0;
            end else if (!dm_req) begin
                if ($urandom_range(2) == 0) begin
                    dm_req = 1'b1; dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
                end
            end else if (granted && m_owner_dm && $urandom_range(1) == 1) begin
                dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
            end
            reset = rst;

            if (rst) begin
                m_issue = -1; m_ack = -1; m_idle = c + 1; m_last_dm = 1'b1;
                exp_if = '0; exp_dm = '0; if_known = 1'b1; dm_known = 1'b1;
            end else if (c >= m_idle && (if_req || dm_req)) begin
                m_owner_dm = dm_req && (!if_req || !m_last_dm);
                m_last_dm  = m_owner_dm;
                m_we       = m_owner_dm && dm_we;
                m_addr     = m_owner_dm ? dm_addr : if_addr;
                m_wdata    = m_owner_dm ? dm_wdata : 32'h0;
                m_issue    = c + 1;
                m_ack      = c + 2 + ML;
                m_idle     = c + 3 + ML;
                if (m_we) model_mem[m_addr] = m_wdata;
                else      m_data = model_rd(m_addr);
            end
        end
        reset = 1'b0;
        inputs_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle CPU between two requesters: the instruction-fetch stage (IF) and the load/store stage (DM).
- Sits between the control FSM/datapath and the memory.
- Sequences each access through a fixed-latency memory, arbitrates simultaneous requests round-robin, and returns read data with a one-cycle acknowledge pulse.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch byte address.
- if_rdata  out  DW  fetched instruction; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for a fetch.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for a data access.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state=IDLE; last_grant=DM; latency counter=0.
- States:
  - IDLE: samples if_req/dm_req.
    - Neither request: stay in IDLE.
    - One request: grant that requester.
    - Both requests: grant the requester that is not last_grant.
    - On grant: latch addr/we/wdata (fetch uses we=0), record owner, update last_grant, go to ISSUE.
  - ISSUE (1 cycle): mem_en=1 with the latched mem_we/mem_addr/mem_wdata. Load counter with MEM_LAT-1. Go to WAIT.
  - WAIT (MEM_LAT cycles): mem_en=0; counter decrements.
    - When counter=0: capture mem_rdata into the owner's rdata register and go to DONE.
    - Stores also traverse WAIT, so all accesses have uniform latency.
  - DONE (1 cycle): owner's ack=1 and rdata valid; requests are not sampled. Go to IDLE.
- Timing:
  - If IDLE samples a request in cycle T, then mem_en is in T+1 and ack is in T+2+MEM_LAT.
  - Minimum issue period is MEM_LAT+3 cycles.
- Request hold rule: a requester keeping req high through its ack cycle is treated as a new request when IDLE samples it in the next cycle.
- Mid-transaction changes: addr/we/wdata/req changes after the grant are ignored. A granted transaction always completes and acks.
- Non-owner request: stays pending, with no ack, until granted.
- rdata retention: if_rdata/dm_rdata hold their value until the next capture for that requester.
- Stores: rdata of the store owner is written with whatever mem_rdata shows (don't-care) but must not corrupt the other requester's rdata.
- Only the owner's ack may pulse; if_ack and dm_ack are never high together.
- Reset in any state forces IDLE on the next edge and clears all outputs. A memory response still in flight is discarded and no ack is generated. last_grant returns to DM.
- MEM_LAT outside 1..15 is a configuration error (elaboration assertion).

Test Plan (MEM_LAT=2):
1. Reset held 2 cycles with random inputs -> all outputs 0, busy=0 throughout and on the first cycle after release.
2. if_req=1, if_addr=0x00000040 sampled at T; memory returns 0x8C080004 at T+3 -> mem_en=1, mem_we=0, mem_addr=0x40 at T+1 only; if_ack=1, if_rdata=0x8C080004 at T+4 only; dm_ack=0 throughout.
3. dm_req=1, dm_we=1, dm_addr=0x00002000, dm_wdata=0xDEADBEEF at T -> at T+1 mem_en=1, mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF; dm_ack at T+4; if_rdata unchanged.
4. Both requests raised at T right after reset -> IF served (mem_en T+1, if_ack T+4); DM sampled T+5, mem_en T+6, dm_ack T+9. Both raised again -> IF wins (last_grant=DM). Then IF-only, followed by a tie -> DM wins.
5. if_req at T, reset pulsed at T+2, memory still drives data at T+3 -> state IDLE at T+3, no if_ack ever, busy=0, mem_en=0.
6. if_req held high continuously with addresses 0x0, 0x4 -> acks at T+4 and T+9 (period 5), mem_addr 0x0 then 0x4, correct data each time.
